oss_hal_reg_master: RTL and testbench

//  Initiator for the oss_hal register interface: accepts queued read/write commands on a

---
 rtl/oss_hal_pkg.sv | 21 ++
 rtl/oss_hal_cmd_fifo.sv | 55 +++++
 rtl/oss_hal_reg_master.sv | 160 ++++++++++++++++
 tb/tb_oss_hal_reg_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oss_hal_pkg.sv
// oss_hal_pkg: shared widths, command record and FSM states for the register master.
package oss_hal_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;

    // One queued register command; data is meaningful for writes only.
    typedef struct packed {
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } reg_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } master_state_e;

endpackage

// File: rtl/oss_hal_cmd_fifo.sv
// oss_hal_cmd_fifo: synchronous command queue with extra-bit pointers for full/empty.
module oss_hal_cmd_fifo
    import oss_hal_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  reg_cmd_t din,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output reg_cmd_t dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;
    reg_cmd_t      mem_q [DEPTH];

    // Pointer MSBs differ only when the writer has lapped the reader.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/oss_hal_reg_master.sv
// oss_hal_reg_master: drains queued commands into one-cycle register strobes and returns read data.
module oss_hal_reg_master
    import oss_hal_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int READ_LATENCY   = 1
) (
    input  logic                  hal_clk,
    input  logic                  hal_reset_n,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic                  cmd_write_in,
    input  logic [REG_ADDR_W-1:0] cmd_addr_in,
    input  logic [REG_DATA_W-1:0] cmd_data_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [REG_ADDR_W-1:0] rsp_addr_out,
    output logic [REG_DATA_W-1:0] rsp_data_out,
    output logic                  reg_itf_write_out,
    output logic                  reg_itf_read_out,
    output logic [REG_ADDR_W-1:0] reg_itf_addr_out,
    output logic [REG_DATA_W-1:0] reg_itf_writedata_out,
    input  logic [REG_DATA_W-1:0] reg_itf_readdata_in,
    output logic                  busy_out
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    master_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [REG_DATA_W-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [REG_ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [REG_DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    reg_cmd_t fifo_din;
    reg_cmd_t fifo_dout;

    // Acceptance depends on queue occupancy only, and is held low while in reset.
    always_comb begin
        cmd_ready_out  = !fifo_full && hal_reset_n;
        fifo_push      = cmd_valid_in && cmd_ready_out;
        fifo_din.write = cmd_write_in;
        fifo_din.addr  = cmd_addr_in;
        fifo_din.data  = cmd_data_in;
    end

    oss_hal_cmd_fifo #(
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (hal_clk),
        .rst_n (hal_reset_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // State and registered-output flops; reset aborts any transaction in flight.
    always_ff @(posedge hal_clk or negedge hal_reset_n) begin
        if (!hal_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next state: writes return to IDLE after the strobe, reads wait out the latency then hold a response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: state_d = write_q ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_in) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: strobes are loaded on the pop so they are high exactly during ISSUE.
    always_comb begin
        fifo_pop    = 1'b0;
        write_d     = 1'b0;
        read_d      = 1'b0;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_dout.addr;
                    write_d  = fifo_dout.write;
                    read_d   = !fifo_dout.write;
                    if (fifo_dout.write) begin
                        wdata_d = fifo_dout.data;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = CNT_W'(READ_LATENCY);
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = addr_q;
                    rsp_data_d  = reg_itf_readdata_in;
                end
            end
            ST_RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Port mapping of the registered outputs and the busy indication.
    always_comb begin
        reg_itf_write_out     = write_q;
        reg_itf_read_out      = read_q;
        reg_itf_addr_out      = addr_q;
        reg_itf_writedata_out = wdata_q;
        rsp_valid_out         = rsp_valid_q;
        rsp_addr_out          = rsp_addr_q;
        rsp_data_out          = rsp_data_q;
        busy_out              = (state_q != ST_IDLE) || !fifo_empty;
    end

endmodule

// File: tb/tb_oss_hal_reg_master.sv
// tb_oss_hal_reg_master: two masters (read latency 1 and 3), each with a responder whose
// register 2 reads back reg0+reg1 and whose read data is poisoned outside the latency slot.
module tb_oss_hal_reg_master;

    localparam logic [31:0] POISON = 32'hBADB_AD00;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } tcmd_t;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] x;
    } vec_t;

    logic hal_clk = 1'b0;
    logic hal_reset_n;

    logic [1:0]       cmd_valid, cmd_ready, cmd_write;
    logic [1:0][3:0]  cmd_addr;
    logic [1:0][31:0] cmd_data;
    logic [1:0]       rsp_valid, rsp_ready;
    logic [1:0][3:0]  rsp_addr;
    logic [1:0][31:0] rsp_data;
    logic [1:0]       reg_write, reg_read, busy;
    logic [1:0][3:0]  reg_addr;
    logic [1:0][31:0] reg_wdata, reg_rdata;

    int total = 0;
    int bad   = 0;

    // Reference model: expected command order, expected responses, register contents.
    tcmd_t       exp_cmd [2][4096];
    logic [35:0] exp_rsp [2][4096];
    int          ch [2], ct [2], rh [2], rt [2];
    int          wr_seen [2], rd_seen [2];
    logic [31:0] mdl_mem [2][16];

    always #5 hal_clk = ~hal_clk;

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] rmem [16] = '{default: 32'd0};
        logic [31:0] pipe [3]  = '{default: POISON};

        // Responder: registered read data, only correct in the latency slot.
        always @(posedge hal_clk) begin
            if (reg_write[g] && reg_addr[g] != 4'd2) begin
                rmem[reg_addr[g]] <= reg_wdata[g];
            end
            pipe[0] <= reg_read[g] ? ((reg_addr[g] == 4'd2) ? rmem[0] + rmem[1] : rmem[reg_addr[g]]) : POISON;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign reg_rdata[g] = pipe[LAT-1];

        oss_hal_reg_master #(
            .CMD_FIFO_DEPTH (4),
            .READ_LATENCY   (LAT)
        ) u_dut (
            .hal_clk               (hal_clk),
            .hal_reset_n           (hal_reset_n),
            .cmd_valid_in          (cmd_valid[g]),
            .cmd_ready_out         (cmd_ready[g]),
            .cmd_write_in          (cmd_write[g]),
            .cmd_addr_in           (cmd_addr[g]),
            .cmd_data_in           (cmd_data[g]),
            .rsp_valid_out         (rsp_valid[g]),
            .rsp_ready_in          (rsp_ready[g]),
            .rsp_addr_out          (rsp_addr[g]),
            .rsp_data_out          (rsp_data[g]),
            .reg_itf_write_out     (reg_write[g]),
            .reg_itf_read_out      (reg_read[g]),
            .reg_itf_addr_out      (reg_addr[g]),
            .reg_itf_writedata_out (reg_wdata[g]),
            .reg_itf_readdata_in   (reg_rdata[g]),
            .busy_out              (busy[g])
        );
    end

    function automatic void checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic logic [31:0] mdlRead(input int i, input logic [3:0] a);
        return (a == 4'd2) ? mdl_mem[i][0] + mdl_mem[i][1] : mdl_mem[i][a];
    endfunction

    // Monitor: every strobe must match the oldest accepted command; every response the oldest read.
    task automatic monitorLoop();
        tcmd_t c;
        forever begin
            @(negedge hal_clk);
            for (int i = 0; i < 2; i++) begin
                if (!hal_reset_n) begin
                    ch[i] = ct[i];
                    rh[i] = rt[i];
                end else begin
                    if (reg_write[i] || reg_read[i]) begin
                        checkOutput("strobe_onehot", 36'(reg_write[i] & reg_read[i]), 36'd0);
                        checkOutput("strobe_has_cmd", 36'(ct[i] > ch[i]), 36'd1);
                        if (ct[i] > ch[i]) begin
                            c = exp_cmd[i][ch[i]];
                            ch[i]++;
                            checkOutput("strobe_type", 36'({reg_write[i], reg_read[i]}), 36'({c.w, !c.w}));
                            checkOutput("strobe_addr", 36'(reg_addr[i]), 36'(c.a));
                            if (c.w) begin
                                checkOutput("write_data", 36'(reg_wdata[i]), 36'(c.d));
                                if (c.a != 4'd2) mdl_mem[i][c.a] = c.d;
                                wr_seen[i]++;
                            end else begin
                                exp_rsp[i][rt[i]] = {c.a, mdlRead(i, c.a)};
                                rt[i]++;
                                rd_seen[i]++;
                            end
                        end
                    end
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        checkOutput("rsp_expected", 36'(rt[i] > rh[i]), 36'd1);
                        if (rt[i] > rh[i]) begin
                            checkOutput("rsp_content", {rsp_addr[i], rsp_data[i]}, exp_rsp[i][rh[i]]);
                            rh[i]++;
                        end
                    end
                    if (cmd_valid[i] && cmd_ready[i]) begin
                        exp_cmd[i][ct[i]] = '{cmd_write[i], cmd_addr[i], cmd_data[i]};
                        ct[i]++;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input int sel, input logic w, input logic [3:0] a, input logic [31:0] d);
        bit done = 1'b0;
        cmd_valid[sel] = 1'b1;
        cmd_write[sel] = w;
        cmd_addr[sel]  = a;
        cmd_data[sel]  = d;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge hal_clk);
            if (cmd_ready[sel]) done = 1'b1;
            @(posedge hal_clk);
            #1;
        end
        cmd_valid[sel] = 1'b0;
        if (!done) checkOutput("push_timeout", 36'(cmd_ready[sel]), 36'd1);
    endtask

    // Returns at a falling edge with the response valid (or after reporting a timeout).
    task automatic waitValid(input int sel);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge hal_clk);
            if (rsp_valid[sel]) seen = 1'b1;
        end
        if (!seen) checkOutput("rsp_timeout", 36'(rsp_valid[sel]), 36'd1);
    endtask

    task automatic waitResponse(input int sel, input logic [3:0] a, input logic [31:0] d);
        waitValid(sel);
        checkOutput("rsp_addr", 36'(rsp_addr[sel]), 36'(a));
        checkOutput("rsp_data", 36'(rsp_data[sel]), 36'(d));
        @(posedge hal_clk);
        #1;
    endtask

    task automatic drain(input int sel);
        bit idle = 1'b0;
        for (int k = 0; k < 500 && !idle; k++) begin
            @(negedge hal_clk);
            if (!busy[sel] && !rsp_valid[sel]) idle = 1'b1;
        end
        @(posedge hal_clk);
        #1;
        checkOutput("drain_idle", 36'(busy[sel]), 36'd0);
        checkOutput("drain_cmds", 36'(ct[sel] - ch[sel]), 36'd0);
        checkOutput("drain_rsps", 36'(rt[sel] - rh[sel]), 36'd0);
    endtask

    task automatic runRandom(input int sel, input int n);
        int sent = 0;
        for (int k = 0; k < 30000 && sent < n; k++) begin
            cmd_valid[sel] = ($urandom_range(0, 3) != 0);
            cmd_write[sel] = 1'($urandom_range(0, 1));
            cmd_addr[sel]  = 4'($urandom_range(0, 15));
            cmd_data[sel]  = $urandom;
            rsp_ready[sel] = ($urandom_range(0, 9) < 7);
            @(negedge hal_clk);
            if (cmd_valid[sel] && cmd_ready[sel]) sent++;
            @(posedge hal_clk);
            #1;
        end
        cmd_valid[sel] = 1'b0;
        rsp_ready[sel] = 1'b1;
        checkOutput("random_sent", 36'(sent), 36'(n));
        drain(sel);
    endtask

    // Watchdog so the run always ends even if a bounded loop is mis-sized.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   wr_before, rd_before;

        tbl[0] = '{1'b1, 4'd0,  32'h0000_0005, 32'd0};
        tbl[1] = '{1'b1, 4'd1,  32'h0000_0003, 32'd0};
        tbl[2] = '{1'b0, 4'd2,  32'd0,         32'h0000_0008};
        tbl[3] = '{1'b0, 4'd0,  32'd0,         32'h0000_0005};
        tbl[4] = '{1'b1, 4'd7,  32'hA5A5_0F0F, 32'd0};
        tbl[5] = '{1'b0, 4'd7,  32'd0,         32'hA5A5_0F0F};
        tbl[6] = '{1'b1, 4'd2,  32'hFFFF_FFFF, 32'd0};
        tbl[7] = '{1'b0, 4'd2,  32'd0,         32'h0000_0008};
        tbl[8] = '{1'b1, 4'd15, 32'h1234_5678, 32'd0};
        tbl[9] = '{1'b0, 4'd15, 32'd0,         32'h1234_5678};

        for (int i = 0; i < 2; i++) begin
            ch[i] = 0; ct[i] = 0; rh[i] = 0; rt[i] = 0;
            wr_seen[i] = 0; rd_seen[i] = 0;
            for (int a = 0; a < 16; a++) mdl_mem[i][a] = 32'd0;
        end
        cmd_valid   = '0;
        cmd_write   = '0;
        cmd_addr    = '0;
        cmd_data    = '0;
        rsp_ready   = '1;
        hal_reset_n = 1'b0;

        fork
            monitorLoop();
        join_none

        // Reset state of both masters.
        repeat (3) @(posedge hal_clk);
        @(negedge hal_clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_write", 36'(reg_write[i]), 36'd0);
            checkOutput("reset_read", 36'(reg_read[i]), 36'd0);
            checkOutput("reset_rsp_valid", 36'(rsp_valid[i]), 36'd0);
            checkOutput("reset_busy", 36'(busy[i]), 36'd0);
        end
        @(posedge hal_clk);
        #1;
        hal_reset_n = 1'b1;
        @(negedge hal_clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("release_ready", 36'(cmd_ready[i]), 36'd1);
            checkOutput("release_addr", 36'(reg_addr[i]), 36'd0);
        end
        @(posedge hal_clk);
        #1;

        $display("[TB] directed table, latency 1");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(0, tbl[v].w, tbl[v].a, tbl[v].d);
            if (!tbl[v].w) waitResponse(0, tbl[v].a, tbl[v].x);
        end
        drain(0);

        $display("[TB] response backpressure");
        applyStimulus(0, 1'b1, 4'd0, 32'hDEAD_BEEF);
        rsp_ready[0] = 1'b0;
        rd_before = rd_seen[0];
        applyStimulus(0, 1'b0, 4'd0, 32'd0);
        waitValid(0);
        for (int j = 0; j < 5; j++) begin
            checkOutput("bp_valid", 36'(rsp_valid[0]), 36'd1);
            checkOutput("bp_data", 36'(rsp_data[0]), 36'hDEAD_BEEF);
            @(negedge hal_clk);
        end
        checkOutput("bp_one_read", 36'(rd_seen[0] - rd_before), 36'd1);
        @(posedge hal_clk);
        #1;
        rsp_ready[0] = 1'b1;
        @(posedge hal_clk);
        #1;
        @(negedge hal_clk);
        checkOutput("bp_valid_drop", 36'(rsp_valid[0]), 36'd0);
        @(posedge hal_clk);
        #1;
        drain(0);

        $display("[TB] queue fill while stalled in response");
        rsp_ready[0] = 1'b0;
        applyStimulus(0, 1'b0, 4'd15, 32'd0);
        waitValid(0);
        @(posedge hal_clk);
        #1;
        wr_before = wr_seen[0];
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 4'(8 + k), 32'h1000_0000 + 32'(k));
        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_addr[0]  = 4'd12;
        cmd_data[0]  = 32'h1000_0004;
        for (int j = 0; j < 3; j++) begin
            @(negedge hal_clk);
            checkOutput("full_ready_low", 36'(cmd_ready[0]), 36'd0);
            checkOutput("full_busy", 36'(busy[0]), 36'd1);
            @(posedge hal_clk);
            #1;
        end
        rsp_ready[0] = 1'b1;
        applyStimulus(0, 1'b1, 4'd12, 32'h1000_0004);
        applyStimulus(0, 1'b1, 4'd13, 32'h1000_0005);
        drain(0);
        checkOutput("fill_writes", 36'(wr_seen[0] - wr_before), 36'd6);

        $display("[TB] latency 3");
        applyStimulus(1, 1'b1, 4'd4, 32'hCAFE_F00D);
        applyStimulus(1, 1'b0, 4'd4, 32'd0);
        waitResponse(1, 4'd4, 32'hCAFE_F00D);
        applyStimulus(1, 1'b1, 4'd6, 32'h1357_9BDF);
        applyStimulus(1, 1'b0, 4'd6, 32'd0);
        waitResponse(1, 4'd6, 32'h1357_9BDF);
        drain(1);

        $display("[TB] reset during read wait");
        applyStimulus(1, 1'b0, 4'd6, 32'd0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge hal_clk);
                if (reg_read[1]) seen = 1'b1;
            end
            checkOutput("wait_read_strobe", 36'(seen), 36'd1);
        end
        @(posedge hal_clk);
        #1;
        cmd_valid[1] = 1'b1;
        cmd_write[1] = 1'b1;
        cmd_addr[1]  = 4'd9;
        cmd_data[1]  = 32'hDDDD_DDDD;
        @(negedge hal_clk);
        checkOutput("extra_push_ready", 36'(cmd_ready[1]), 36'd1);
        @(posedge hal_clk);
        #1;
        cmd_valid[1] = 1'b0;
        #1;
        hal_reset_n = 1'b0;
        #1;
        checkOutput("rst_read", 36'(reg_read[1]), 36'd0);
        checkOutput("rst_write", 36'(reg_write[1]), 36'd0);
        checkOutput("rst_rsp_valid", 36'(rsp_valid[1]), 36'd0);
        checkOutput("rst_busy", 36'(busy[1]), 36'd0);
        @(negedge hal_clk);
        @(posedge hal_clk);
        #1;
        hal_reset_n = 1'b1;
        @(negedge hal_clk);
        checkOutput("rst_release_ready", 36'(cmd_ready[1]), 36'd1);
        checkOutput("rst_release_busy", 36'(busy[1]), 36'd0);
        @(posedge hal_clk);
        #1;
        applyStimulus(1, 1'b0, 4'd4, 32'd0);
        waitResponse(1, 4'd4, 32'hCAFE_F00D);
        applyStimulus(1, 1'b0, 4'd9, 32'd0);
        waitResponse(1, 4'd9, 32'd0);
        drain(1);

        $display("[TB] random traffic");
        runRandom(0, 1000);
        runRandom(1, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
